floor_request_latch: RTL and testbench
======================================

// Module: floor_request_latch
// PURPOSE
// - Upstream stage of the direction scoring logic. Debounces raw hall-call and cab buttons for two cars.
// - Latches each press as a pending request. Drives FloorsRequested / FloorDestinations into the scoring stage.
// - Runs a per-car door-dwell FSM. The FSM clears served requests once a car stops at a requested floor.
// - Bits [5:0] belong to the left car (car 0); bits [11:6] belong to the right car (car 1).
// PARAMETERS
// - TICK_DIV     1000  clk cycles per sample tick (1 ms at 1 MHz); 1..4095
// - DB_SAMPLES   4     consecutive high ticks needed to accept a press; 1..15
// - DWELL_TICKS  60    ticks the door stays open at a served floor; 1..255
// PORTS
// - clk                 in   1   system clock
// - rst                 in   1   asynchronous, active-high reset
// - hall_btn            in   12  raw hall-call buttons, async, active-high
// - cab_btn             in   12  raw cab destination buttons, async, active-high
// - elevator_position   in   8   [7:4] car0, [3:0] car1; even value 2f = at floor f, odd = between floors
// - FloorsRequested     out  12  latched hall calls
// - FloorDestinations   out  12  latched cab destinations
// - door_open           out  2   per-car door open; scoring stage must hold the car while high
// - served_pulse        out  2   one-clk pulse when a car's requests are cleared
// BEHAVIOUR
// - Reset values: FloorsRequested=0, FloorDestinations=0, door_open=0, served_pulse=0.
//   Tick prescaler, debounce counters and FSMs also reset to 0 / IDLE.
// - Synchronizer: every btn bit passes through a 2-FF synchronizer before any other use.
// - Tick: prescaler counts 0..TICK_DIV-1. tick=1 for one clk when the count wraps to 0.
// - Debounce (24 independent counters):
//   - On tick, a synced-high button increments its counter, saturating at DB_SAMPLES.
//   - On tick, a synced-low button clears its counter to 0.
//   - Accept event: the counter reaches DB_SAMPLES. Fires once per press; holding the button does not re-fire.
// - Latch: an accepted event sets the matching request bit on the next clk.
// - Position decode per car: at_floor = (pos[0]==0) && (pos>>1) <= 5; floor = pos>>1.
//   Odd or out-of-range positions never trigger service.
// - Service FSM (one per car, encoded 2 bits):
//   - IDLE -> OPEN:
//     - Condition: at_floor, and the hall or cab bit for that floor and car is set.
//     - Action: door_open=1 from the next clk; dwell counter loads 0.
//   - OPEN: dwell counter increments on tick.
//   - OPEN -> CLEAR: dwell counter == DWELL_TICKS-1 on a tick.
//   - CLEAR (1 clk):
//     - Clears the hall and cab bits for the car's current floor.
//     - served_pulse=1, door_open=0.
//     - Next state is IDLE.
//   - While in OPEN, elevator_position for that car is ignored; the floor is captured on IDLE->OPEN.
//   - door_open depends only on state (registered); it is high exactly in OPEN.
// - Simultaneous events:
//   - A press that is accepted at the served floor during OPEN or CLEAR is dropped; the passenger is already served.
//   - A set and a clear of the same bit in the same clk: clear wins.
//   - Presses for other floors latch normally during OPEN.
// - Cars are fully independent; both can be in OPEN at once.
// - Reset mid-dwell: door_open drops asynchronously; all requests are lost.
// CONFIGURATION
// - Macro: CAB_CANCEL_EN
//   - Defined: an accepted cab press whose destination bit is already set clears that bit (toggle/cancel).
//     The same-floor drop rule still applies.
//   - Undefined: accepted presses only set bits; a re-press of a latched bit has no effect.
//   - Hall calls never cancel in either build.
// TESTING (TICK_DIV=4, DB_SAMPLES=3, DWELL_TICKS=5 unless noted)
// - Debounce:
//   - Stimulus: hall_btn[2] high for 2 ticks, then low.
//   - Required: FloorsRequested stays 0.
//   - Stimulus: hall_btn[2] held for 3 ticks.
//   - Required: FloorsRequested=12'h004 and stays set after release.
// - Service:
//   - Stimulus: cab_btn[9] latched; car1 position = 4'd6 (floor 3).
//   - Required: door_open[1]=1 for 5 ticks (20 clk).
//   - Required: then served_pulse[1]=1 for 1 clk, FloorDestinations[9]=0, door_open[1]=0.
// - Between floors:
//   - Stimulus: hall_btn[1] latched; car0 position = 4'd3.
//   - Required: no door_open[0].
//   - Stimulus: position moves to 4'd2.
//   - Required: door_open[0] rises the next clk.
// - Same-floor drop:
//   - Stimulus: during OPEN at car0 floor 4, hall_btn[4] is accepted.
//   - Required: bit 4 = 0 after CLEAR.
//   - Stimulus: hall_btn[5] pressed at the same time.
//   - Required: bit 5 = 1 after CLEAR.
// - Cancel (CAB_CANCEL_EN):
//   - Stimulus: cab_btn[0] pressed twice, each press debounced and released between.
//   - Required: FloorDestinations[0] goes 1 then 0.
//   - Without the macro: stays 1.
// - Reset mid-op:
//   - Stimulus: rst asserted while both cars are in OPEN with requests 12'hFFF.
//   - Required: all outputs 0 in the same cycle; FSMs IDLE after release.

Source files
------------

// File: rtl/floor_request_latch.sv
// floor_request_latch
//   Debounces raw hall-call and cab buttons for two cars, latches accepted
//   presses as pending requests and runs a per-car door-dwell FSM that clears
//   a floor's requests once the car has stopped there for the dwell time.
//   Bits [5:0] belong to car 0 (left), bits [11:6] to car 1 (right).
//
//   Optional build macro: CAB_CANCEL_EN
//     defined   - an accepted cab press on an already-latched destination
//                 clears it (toggle/cancel); hall calls never cancel.
//     undefined - accepted presses only ever set request bits.
//
// Ports
//   clk                in  system clock
//   rst                in  asynchronous, active-high reset
//   hall_btn[11:0]     in  raw hall-call buttons (async)
//   cab_btn[11:0]      in  raw cab destination buttons (async)
//   elevator_position  in  [7:4] car0, [3:0] car1; even 2f = at floor f
//   FloorsRequested    out latched hall calls
//   FloorDestinations  out latched cab destinations
//   door_open[1:0]     out high exactly while a car is in OPEN
//   served_pulse[1:0]  out one-clk pulse when a car's floor is cleared
module floor_request_latch #(
  parameter int TICK_DIV    = 1000,
  parameter int DB_SAMPLES  = 4,
  parameter int DWELL_TICKS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hall_btn,
  input  logic [11:0] cab_btn,
  input  logic [7:0]  elevator_position,
  output logic [11:0] FloorsRequested,
  output logic [11:0] FloorDestinations,
  output logic [1:0]  door_open,
  output logic [1:0]  served_pulse
);

  localparam int NUM_CARS = 2;
  localparam int NUM_BTN  = 24;

  typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, CLEAR = 2'd2} svc_state_t;

  // {cab, hall} through a 2-FF synchronizer before any other use
  logic [NUM_BTN-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {cab_btn, hall_btn};
      sync2 <= sync1;
    end
  end

  // Sample tick prescaler
  logic [11:0] pre_cnt;
  logic        tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == 12'(TICK_DIV-1));
      pre_cnt <= (pre_cnt == 12'(TICK_DIV-1)) ? '0 : pre_cnt + 12'd1;
    end
  end

  // Debounce: the counter saturates at DB_SAMPLES, so the accept strobe
  // (the step from DB_SAMPLES-1 to DB_SAMPLES) fires once per press.
  logic [NUM_BTN-1:0][3:0] db_cnt;
  logic [NUM_BTN-1:0]      accept;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++)
      accept[i] = tick && sync2[i] && (db_cnt[i] == 4'(DB_SAMPLES-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!sync2[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != 4'(DB_SAMPLES))
          db_cnt[i] <= db_cnt[i] + 4'd1;
      end
    end
  end

  // Per-car service state
  svc_state_t          state   [NUM_CARS];
  logic [2:0]          floor_q [NUM_CARS];
  logic [7:0]          dwell   [NUM_CARS];
  logic [NUM_CARS-1:0][3:0] pos;
  logic [NUM_CARS-1:0] hit;
  logic [NUM_CARS-1:0] done_evt;
  logic [11:0]         clr_mask;
  logic [11:0]         drop_mask;
  logic [5:0]          floor_oh;
  logic [5:0]          served_oh;
  logic [5:0]          req_car;

  assign pos[0] = elevator_position[7:4];
  assign pos[1] = elevator_position[3:0];

  // clr_mask: floor being cleared this clk (OPEN->CLEAR edge).
  // drop_mask: floor a busy car is serving; presses there are discarded.
  always_comb begin
    hit       = '0;
    done_evt  = '0;
    clr_mask  = '0;
    drop_mask = '0;
    floor_oh  = '0;
    served_oh = '0;
    req_car   = '0;
    for (int c = 0; c < NUM_CARS; c++) begin
      floor_oh  = 6'b1 << pos[c][3:1];
      req_car   = FloorsRequested[c*6 +: 6] | FloorDestinations[c*6 +: 6];
      hit[c]    = !pos[c][0] && (pos[c][3:1] <= 3'd5) && |(floor_oh & req_car);
      served_oh = 6'b1 << floor_q[c];
      done_evt[c] = (state[c] == OPEN) && tick && (dwell[c] == 8'(DWELL_TICKS-1));
      if (done_evt[c])
        clr_mask[c*6 +: 6] = served_oh;
      if (state[c] != IDLE)
        drop_mask[c*6 +: 6] = served_oh;
    end
  end

  // Request latches; clear is applied last so it wins over a same-clk set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FloorsRequested   <= '0;
      FloorDestinations <= '0;
    end else begin
      FloorsRequested <= (FloorsRequested | (accept[11:0] & ~drop_mask)) & ~clr_mask;
`ifdef CAB_CANCEL_EN
      FloorDestinations <= (FloorDestinations ^ (accept[23:12] & ~drop_mask)) & ~clr_mask;
`else
      FloorDestinations <= (FloorDestinations | (accept[23:12] & ~drop_mask)) & ~clr_mask;
`endif
    end
  end

  // Door-dwell FSMs; floor is captured on entry so position is ignored in OPEN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CARS; c++) begin
        state[c]   <= IDLE;
        floor_q[c] <= '0;
        dwell[c]   <= '0;
      end
      door_open    <= '0;
      served_pulse <= '0;
    end else begin
      for (int c = 0; c < NUM_CARS; c++) begin
        case (state[c])
          IDLE: begin
            if (hit[c]) begin
              state[c]     <= OPEN;
              floor_q[c]   <= pos[c][3:1];
              dwell[c]     <= '0;
              door_open[c] <= 1'b1;
            end
          end
          OPEN: begin
            if (done_evt[c]) begin
              state[c]        <= CLEAR;
              door_open[c]    <= 1'b0;
              served_pulse[c] <= 1'b1;
            end else if (tick) begin
              dwell[c] <= dwell[c] + 8'd1;
            end
          end
          CLEAR: begin
            state[c]        <= IDLE;
            served_pulse[c] <= 1'b0;
          end
          default: begin
            state[c]        <= IDLE;
            door_open[c]    <= 1'b0;
            served_pulse[c] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_floor_request_latch.sv
module tb_floor_request_latch;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int DW = 5;

`ifdef CAB_CANCEL_EN
  localparam logic [11:0] CANCEL_DST = 12'h000;
`else
  localparam logic [11:0] CANCEL_DST = 12'h001;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hall_btn, cab_btn;
  logic [7:0]  elevator_position;
  logic [11:0] FloorsRequested, FloorDestinations;
  logic [1:0]  door_open, served_pulse;

  floor_request_latch #(.TICK_DIV(TD), .DB_SAMPLES(DB), .DWELL_TICKS(DW)) dut (
    .clk(clk), .rst(rst), .hall_btn(hall_btn), .cab_btn(cab_btn),
    .elevator_position(elevator_position),
    .FloorsRequested(FloorsRequested), .FloorDestinations(FloorDestinations),
    .door_open(door_open), .served_pulse(served_pulse));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: clk count since reset, run lengths of high ticks per
  // button, request bit arrays and per-car "door open with N ticks left".
  int          cyc;
  logic [23:0] m_s1, m_s2;
  int          run [24];
  logic [11:0] m_h, m_c;
  bit          m_open [2];
  bit          m_clr  [2];
  int          m_floor[2];
  int          m_left [2];

  task automatic model_reset();
    cyc = 0; m_s1 = '0; m_s2 = '0; m_h = '0; m_c = '0;
    for (int i = 0; i < 24; i++) run[i] = 0;
    for (int c = 0; c < 2; c++) begin
      m_open[c] = 0; m_clr[c] = 0; m_floor[c] = 0; m_left[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit          tk;
    bit [23:0]   acc;
    bit [11:0]   clr;
    bit          n_open[2];
    bit          n_clr[2];
    int          p, b, c, f;
    tk  = (cyc > 0) && (cyc % TD == 0);
    acc = '0;
    clr = '0;
    for (int i = 0; i < 24; i++) begin
      if (tk) begin
        if (m_s2[i]) begin
          run[i]++;
          if (run[i] == DB) acc[i] = 1'b1;
        end else run[i] = 0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_open[k] = m_open[k];
      n_clr[k]  = 1'b0;
      p = (k == 0) ? int'(elevator_position[7:4]) : int'(elevator_position[3:0]);
      if (m_clr[k]) begin
        n_open[k] = 1'b0;
      end else if (m_open[k]) begin
        if (tk) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            n_open[k] = 1'b0;
            n_clr[k]  = 1'b1;
            clr[k*6 + m_floor[k]] = 1'b1;
          end
        end
      end else if (p % 2 == 0 && p / 2 <= 5 && (m_h[k*6 + p/2] || m_c[k*6 + p/2])) begin
        n_open[k]  = 1'b1;
        m_floor[k] = p / 2;
        m_left[k]  = DW;
      end
    end
    for (int i = 0; i < 24; i++) begin
      if (acc[i]) begin
        b = i % 12; c = b / 6; f = b % 6;
        if (!((m_open[c] || m_clr[c]) && m_floor[c] == f)) begin
          if (i < 12) m_h[b] = 1'b1;
`ifdef CAB_CANCEL_EN
          else        m_c[b] = !m_c[b];
`else
          else        m_c[b] = 1'b1;
`endif
        end
      end
    end
    m_h = m_h & ~clr;
    m_c = m_c & ~clr;
    for (int k = 0; k < 2; k++) begin
      m_open[k] = n_open[k];
      m_clr[k]  = n_clr[k];
    end
    m_s2 = m_s1;
    m_s1 = {cab_btn, hall_btn};
    cyc++;
  endtask

  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got req/dst/door/served=%h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [27:0] dut_out();
    return {FloorsRequested, FloorDestinations, door_open, served_pulse};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", dut_out(),
        {m_h, m_c, m_open[1], m_open[0], m_clr[1], m_clr[0]});
  endtask

  typedef struct {
    logic [11:0] hall;
    logic [11:0] cab;
    logic [7:0]  pos;
    int          ncyc;
    logic [11:0] exp_req;
    logic [11:0] exp_dst;
    logic [1:0]  exp_door;
  } vec_t;

  vec_t tbl [24];

  initial begin
    // debounce: 2 ticks rejected, 3 ticks accepted and held
    tbl[0]  = '{12'h000, 12'h000, 8'h11, 4,  12'h000, 12'h000, 2'b00};
    tbl[1]  = '{12'h004, 12'h000, 8'h11, 8,  12'h000, 12'h000, 2'b00};
    tbl[2]  = '{12'h000, 12'h000, 8'h11, 8,  12'h000, 12'h000, 2'b00};
    tbl[3]  = '{12'h004, 12'h000, 8'h11, 16, 12'h004, 12'h000, 2'b00};
    tbl[4]  = '{12'h000, 12'h000, 8'h11, 8,  12'h004, 12'h000, 2'b00};
    // service car1 at floor 3 for cab bit 9
    tbl[5]  = '{12'h000, 12'h200, 8'h11, 16, 12'h004, 12'h200, 2'b00};
    tbl[6]  = '{12'h000, 12'h000, 8'h16, 2,  12'h004, 12'h200, 2'b10};
    tbl[7]  = '{12'h000, 12'h000, 8'h16, 10, 12'h004, 12'h200, 2'b10};
    tbl[8]  = '{12'h000, 12'h000, 8'h16, 16, 12'h004, 12'h000, 2'b00};
    // between floors, then arrive
    tbl[9]  = '{12'h002, 12'h000, 8'h11, 16, 12'h006, 12'h000, 2'b00};
    tbl[10] = '{12'h000, 12'h000, 8'h31, 8,  12'h006, 12'h000, 2'b00};
    tbl[11] = '{12'h000, 12'h000, 8'h21, 1,  12'h006, 12'h000, 2'b01};
    tbl[12] = '{12'h000, 12'h000, 8'h21, 30, 12'h004, 12'h000, 2'b00};
    // same-floor drop at car0 floor 4, floor 5 latches
    tbl[13] = '{12'h010, 12'h000, 8'h11, 16, 12'h014, 12'h000, 2'b00};
    tbl[14] = '{12'h000, 12'h000, 8'h11, 8,  12'h014, 12'h000, 2'b00};
    tbl[15] = '{12'h000, 12'h000, 8'h81, 1,  12'h014, 12'h000, 2'b01};
    tbl[16] = '{12'h030, 12'h000, 8'h81, 14, 12'h034, 12'h000, 2'b01};
    tbl[17] = '{12'h000, 12'h000, 8'h81, 12, 12'h024, 12'h000, 2'b00};
    // cab re-press (cancel build toggles)
    tbl[18] = '{12'h000, 12'h001, 8'h11, 16, 12'h024, 12'h001, 2'b00};
    tbl[19] = '{12'h000, 12'h000, 8'h11, 8,  12'h024, 12'h001, 2'b00};
    tbl[20] = '{12'h000, 12'h001, 8'h11, 16, 12'h024, CANCEL_DST, 2'b00};
    tbl[21] = '{12'h000, 12'h000, 8'h11, 8,  12'h024, CANCEL_DST, 2'b00};
    // everything latched, both cars open
    tbl[22] = '{12'hFFF, 12'hFFF, 8'h11, 16, 12'hFFF, 12'hFFF, 2'b00};
    tbl[23] = '{12'hFFF, 12'hFFF, 8'h00, 2,  12'hFFF, 12'hFFF, 2'b11};

    rst = 1'b1;
    hall_btn = '0; cab_btn = '0; elevator_position = 8'h11;
    model_reset();
    @(posedge clk); #1;
    chk("reset_state", dut_out(), 28'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < 24; r++) begin
      hall_btn = tbl[r].hall;
      cab_btn  = tbl[r].cab;
      elevator_position = tbl[r].pos;
      repeat (tbl[r].ncyc) step();
      chk($sformatf("row%0d", r), dut_out(),
          {tbl[r].exp_req, tbl[r].exp_dst, tbl[r].exp_door, 2'b00});
    end

    // asynchronous reset while both cars are open
    rst = 1'b1;
    #1;
    chk("reset_mid_dwell", dut_out(), 28'h0);
    model_reset();
    hall_btn = '0; cab_btn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) step();
    chk("post_reset_idle", dut_out(), 28'h0);

    // randomized traffic against the model
    begin
      int hold_b = 0;
      int hold_p = 0;
      for (int k = 0; k < 3000; k++) begin
        if (hold_b == 0) begin
          hall_btn = 12'($urandom & $urandom & $urandom & $urandom);
          cab_btn  = 12'($urandom & $urandom & $urandom & $urandom);
          hold_b   = $urandom_range(12, 40);
        end
        if (hold_p == 0) begin
          elevator_position = 8'($urandom);
          hold_p = $urandom_range(10, 60);
        end
        hold_b--;
        hold_p--;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
